// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 8-digit 7-seg scan controller with double-buffered frame
module display_scan_controller #(
  parameter int DWELL_CYCLES = 1000,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] frame_hex,
  input  logic [7:0]  frame_dp,
  input  logic [7:0]  frame_blank,
  input  logic        update,
  input  logic        busy,
  output logic [15:0] data16,
  output logic        start,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, ACK, SHIFT, DWELL} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [AW-1:0] ack_cnt;
  logic [DW-1:0] dwell_cnt;

  // Active buffer feeds the display; pending buffer collects updates between frames.
  logic [31:0] act_hex, pend_hex;
  logic [7:0]  act_dp, pend_dp;
  logic [7:0]  act_blank, pend_blank;
  logic        pend_flag;

  logic [3:0]  cur_hex;
  logic        cur_dp;
  logic        cur_blank;
  logic        frame_boundary;
  logic        do_copy;

  // Active-low segment pattern: bit0=a .. bit6=g, bit7=dp.
  function automatic logic [7:0] seg_encode(input logic [3:0] hex, input logic dp,
                                            input logic blank);
    logic [6:0] g;
    case (hex)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    seg_encode = blank ? 8'hFF : {~dp, g};
  endfunction

  assign cur_hex   = act_hex[{idx, 2'b00} +: 4];
  assign cur_dp    = act_dp[idx];
  assign cur_blank = act_blank[idx];

  // Frame boundaries are the only points where pending may replace the active frame.
  always_comb begin
    frame_boundary = 1'b0;
    if (state == IDLE && enable)
      frame_boundary = 1'b1;
    if (state == DWELL && dwell_cnt == '0 && idx == 3'd7)
      frame_boundary = 1'b1;
    do_copy = frame_boundary && pend_flag;
  end

  // Scan FSM, buffer management and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      ack_cnt     <= '0;
      dwell_cnt   <= '0;
      data16      <= 16'hFFFF;
      start       <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      act_hex     <= 32'h0;
      act_dp      <= 8'h00;
      act_blank   <= 8'hFF;
      pend_hex    <= 32'h0;
      pend_dp     <= 8'h00;
      pend_blank  <= 8'hFF;
      pend_flag   <= 1'b0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;

      if (do_copy) begin
        act_hex   <= pend_hex;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end

      // An update coinciding with a copy lands in pending and keeps the flag set.
      if (update) begin
        pend_hex   <= frame_hex;
        pend_dp    <= frame_dp;
        pend_blank <= frame_blank;
        pend_flag  <= 1'b1;
      end else if (do_copy) begin
        pend_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable)
            state <= LOAD;
        end
        LOAD: begin
          data16 <= {seg_encode(cur_hex, cur_dp, cur_blank), ~(8'b1 << idx)};
          state  <= SEND;
        end
        SEND: begin
          if (!busy) begin
            start   <= 1'b1;
            ack_cnt <= '0;
            state   <= ACK;
          end
        end
        ACK: begin
          if (busy) begin
            state <= SHIFT;
          end else if (ack_cnt == ACK_LAST) begin
            timeout_err <= 1'b1;
            state       <= SEND;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!busy) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt == '0) begin
            if (idx == 3'd7) begin
              frame_done <= 1'b1;
              idx        <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
            state <= enable ? LOAD : IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
